// File: rtl/trireg_pkg.sv
// Shared types and per-bit wired resolution for the trireg hold array.
package trireg_pkg;

  typedef enum logic [1:0] {
    DRIVEN  = 2'd0,
    HOLD    = 2'd1,
    DECAYED = 2'd2
  } trireg_state_t;

  // Returns {val, xmask} for one bit; with both drivers on, disagreement marks the bit X.
  function automatic logic [1:0] resolve2(input logic a_en, input logic a_val,
                                          input logic b_en, input logic b_val);
    logic [1:0] r;
    case ({a_en, b_en})
      2'b11:   r = {a_val, a_val ^ b_val};
      2'b10:   r = {a_val, 1'b0};
      2'b01:   r = {b_val, 1'b0};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/trireg_hold_cell.sv
// One trireg channel: two-driver resolution, charge hold, optional decay to X.
// Decay is built only when TRIREG_HOLD_DECAY_EN is defined; otherwise charge is held forever.
module trireg_hold_cell
  import trireg_pkg::*;
#(
  parameter int unsigned W            = 8,
  parameter int unsigned DECAY_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_en,
  input  logic [W-1:0] a_val,
  input  logic         b_en,
  input  logic [W-1:0] b_val,
  output logic [W-1:0] q_val,
  output logic [W-1:0] q_xmask,
  output logic         held,
  output logic         decay_pulse
);

  if (DECAY_CYCLES == 0) begin : g_bad_param
    $error("DECAY_CYCLES must be at least 1");
  end

  trireg_state_t state_q, state_d;
  logic [W-1:0]  val_q, val_d;
  logic [W-1:0]  xmask_q, xmask_d;
  logic          held_q, held_d;

`ifdef TRIREG_HOLD_DECAY_EN
  localparam int unsigned CntW = $clog2(DECAY_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;
`endif

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    xmask_d = xmask_q;
    held_d  = held_q;
`ifdef TRIREG_HOLD_DECAY_EN
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
`endif
    if (a_en || b_en) begin
      for (int i = 0; i < W; i++) begin
        {val_d[i], xmask_d[i]} = resolve2(a_en, a_val[i], b_en, b_val[i]);
      end
      state_d = DRIVEN;
      held_d  = 1'b0;
    end else begin
      unique case (state_q)
        DRIVEN: begin
`ifdef TRIREG_HOLD_DECAY_EN
          if (DECAY_CYCLES == 1) begin
            state_d = DECAYED;
            xmask_d = '1;
            held_d  = 1'b0;
            pulse_d = 1'b1;
          end else begin
            state_d = HOLD;
            cnt_d   = CntW'(DECAY_CYCLES - 1);
            held_d  = 1'b1;
          end
`else
          state_d = HOLD;
          held_d  = 1'b1;
`endif
        end
        HOLD: begin
`ifdef TRIREG_HOLD_DECAY_EN
          if (cnt_q == CntW'(1)) begin
            state_d = DECAYED;
            xmask_d = '1;
            held_d  = 1'b0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
`endif
        end
        DECAYED: begin
        end
        // Unused encoding: fall back to the safe unknown state without pulsing.
        default: begin
          state_d = DECAYED;
          xmask_d = '1;
          held_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DECAYED;
      val_q   <= '0;
      xmask_q <= '1;
      held_q  <= 1'b0;
`ifdef TRIREG_HOLD_DECAY_EN
      cnt_q   <= '0;
      pulse_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      xmask_q <= xmask_d;
      held_q  <= held_d;
`ifdef TRIREG_HOLD_DECAY_EN
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
`endif
    end
  end

  assign q_val   = val_q;
  assign q_xmask = xmask_q;
  assign held    = held_q;
`ifdef TRIREG_HOLD_DECAY_EN
  assign decay_pulse = pulse_q;
`else
  assign decay_pulse = 1'b0;
`endif

endmodule

// File: rtl/trireg_hold_array.sv
// NCH independent trireg channels; slices the packed buses onto one cell per channel.
// Decay to X is enabled by defining TRIREG_HOLD_DECAY_EN.
module trireg_hold_array
  import trireg_pkg::*;
#(
  parameter int unsigned NCH          = 4,
  parameter int unsigned W            = 8,
  parameter int unsigned DECAY_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   a_en,
  input  logic [NCH*W-1:0] a_val,
  input  logic [NCH-1:0]   b_en,
  input  logic [NCH*W-1:0] b_val,
  output logic [NCH*W-1:0] q_val,
  output logic [NCH*W-1:0] q_xmask,
  output logic [NCH-1:0]   held,
  output logic [NCH-1:0]   decay_pulse
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    trireg_hold_cell #(
      .W            (W),
      .DECAY_CYCLES (DECAY_CYCLES)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .a_en        (a_en[c]),
      .a_val       (a_val[c*W +: W]),
      .b_en        (b_en[c]),
      .b_val       (b_val[c*W +: W]),
      .q_val       (q_val[c*W +: W]),
      .q_xmask     (q_xmask[c*W +: W]),
      .held        (held[c]),
      .decay_pulse (decay_pulse[c])
    );
  end

endmodule
